// File: rtl/gravity_pkg.sv
// Shared defaults, counter action encoding and the level/soft-drop period calculation
// used by gravity_timer and period_counter.
package gravity_pkg;

   localparam int DEF_BASE_PERIOD = 25_000_000;
   localparam int DEF_STEP        = 2_000_000;
   localparam int DEF_MIN_PERIOD  = 2_500_000;
   localparam int DEF_LEVEL_W     = 4;
   localparam int DEF_SOFT_SHIFT  = 3;
   localparam int DEF_LOCK_PERIOD = 50_000_000;

   typedef enum logic [1:0] {
      ACT_CLEAR = 2'd0,
      ACT_HOLD  = 2'd1,
      ACT_WRAP  = 2'd2,
      ACT_INC   = 2'd3
   } cnt_action_e;

   // Wide intermediates keep level*step and the clamp free of overflow for any legal level.
   function automatic logic [31:0] calc_period(
      input logic [31:0] level,
      input logic        soft_drop,
      input logic [31:0] base_period,
      input logic [31:0] step,
      input logic [31:0] min_period,
      input int          soft_shift
   );
      logic [63:0] product;
      logic [63:0] lvl_p;
      logic [63:0] eff_p;
      product = 64'(level) * 64'(step);
      if (product >= 64'(base_period)) begin
         lvl_p = '0;
      end else begin
         lvl_p = 64'(base_period) - product;
      end
      if (lvl_p < 64'(min_period)) begin
         lvl_p = 64'(min_period);
      end
      eff_p = lvl_p;
      if (soft_drop) begin
         eff_p = lvl_p >> soft_shift;
         if (eff_p == '0) begin
            eff_p = 64'd1;
         end
      end
      return 32'(eff_p);
   endfunction

endpackage

// File: rtl/gravity_timer_period_counter.sv
// period_counter: free-running count with clear > hold > terminal > increment priority
// and a registered one-cycle tick on wrap. period must be >= 1.
module period_counter
   import gravity_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         hold,
   input  logic [W-1:0] period,
   output logic [W-1:0] count,
   output logic         tick
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         tick_q;
   logic         tick_d;
   logic         terminal;
   cnt_action_e  action;

   // >= rather than == so a period that shrinks below the current count wraps at once.
   assign terminal = (count_q >= (period - W'(1)));

   always_comb begin
      action = ACT_INC;
      if (clr) begin
         action = ACT_CLEAR;
      end else if (hold) begin
         action = ACT_HOLD;
      end else if (terminal) begin
         action = ACT_WRAP;
      end
   end

   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      unique case (action)
         ACT_CLEAR: count_d = '0;
         ACT_HOLD:  count_d = count_q;
         ACT_WRAP: begin
            count_d = '0;
            tick_d  = 1'b1;
         end
         default:   count_d = count_q + W'(1);
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;

endmodule

// File: rtl/gravity_timer.sv
// gravity_timer: level-scaled gravity tick with soft-drop, pause and restart.
// Define GRAVITY_LOCK_EN to add the grounded lock-delay counter and lockPiece output.
module gravity_timer
   import gravity_pkg::*;
#(
   parameter  int BASE_PERIOD = DEF_BASE_PERIOD,
   parameter  int STEP        = DEF_STEP,
   parameter  int MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter  int LEVEL_W     = DEF_LEVEL_W,
   parameter  int SOFT_SHIFT  = DEF_SOFT_SHIFT,
   parameter  int LOCK_PERIOD = DEF_LOCK_PERIOD,
   localparam int CNT_W       = $clog2(BASE_PERIOD + 1)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [LEVEL_W-1:0] level,
   input  logic               softDrop,
   input  logic               pause,
   input  logic               rstTimer,
   output logic [CNT_W-1:0]   timeVal,
   output logic               moveDown
`ifdef GRAVITY_LOCK_EN
   ,
   input  logic               grounded,
   output logic               lockPiece
`endif
);

   logic [CNT_W-1:0] eff_period;
   logic [CNT_W-1:0] grav_count;
   logic             grav_tick;

   assign eff_period = CNT_W'(calc_period(32'(level), softDrop, 32'(BASE_PERIOD),
                                          32'(STEP), 32'(MIN_PERIOD), SOFT_SHIFT));

   period_counter #(
      .W(CNT_W)
   ) u_grav (
      .clk    (clk),
      .rst    (rst),
      .clr    (rstTimer),
      .hold   (pause),
      .period (eff_period),
      .count  (grav_count),
      .tick   (grav_tick)
   );

   assign timeVal = grav_count;

`ifdef GRAVITY_LOCK_EN
   localparam int LOCK_W = $clog2(LOCK_PERIOD + 1);

   logic [LOCK_W-1:0] lock_count_unused;
   logic              lock_tick;

   period_counter #(
      .W(LOCK_W)
   ) u_lock (
      .clk    (clk),
      .rst    (rst),
      .clr    (!grounded || rstTimer),
      .hold   (pause),
      .period (LOCK_W'(LOCK_PERIOD)),
      .count  (lock_count_unused),
      .tick   (lock_tick)
   );

   // A lock request takes precedence: the piece locks instead of moving that cycle.
   assign lockPiece = lock_tick;
   assign moveDown  = grav_tick & ~lock_tick;
`else
   localparam int LOCK_PERIOD_UNUSED = LOCK_PERIOD;

   assign moveDown = grav_tick;
`endif

endmodule

// File: tb/tb_gravity_timer.sv
// Randomized and directed check of gravity_timer against a cycle-level behavioural model.
module tb_gravity_timer;

   localparam int BASE_PERIOD = 100;
   localparam int STEP        = 10;
   localparam int MIN_PERIOD  = 20;
   localparam int LEVEL_W     = 4;
   localparam int SOFT_SHIFT  = 2;
   localparam int LOCK_PERIOD = 50;
   localparam int CNT_W       = $clog2(BASE_PERIOD + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [LEVEL_W-1:0] level = '0;
   logic               softDrop = 1'b0;
   logic               pause = 1'b0;
   logic               rstTimer = 1'b0;
   logic [CNT_W-1:0]   timeVal;
   logic               moveDown;
`ifdef GRAVITY_LOCK_EN
   logic               grounded = 1'b0;
   logic               lockPiece;
`endif

   int vectors     = 0;
   int miscompares = 0;

   int m_cnt = 0;
   bit m_md  = 1'b0;
   int m_lc  = 0;
   bit m_lp  = 1'b0;

   always #5 clk = ~clk;

   gravity_timer #(
      .BASE_PERIOD (BASE_PERIOD),
      .STEP        (STEP),
      .MIN_PERIOD  (MIN_PERIOD),
      .LEVEL_W     (LEVEL_W),
      .SOFT_SHIFT  (SOFT_SHIFT),
      .LOCK_PERIOD (LOCK_PERIOD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .level     (level),
      .softDrop  (softDrop),
      .pause     (pause),
      .rstTimer  (rstTimer),
      .timeVal   (timeVal),
      .moveDown  (moveDown)
`ifdef GRAVITY_LOCK_EN
      ,
      .grounded  (grounded),
      .lockPiece (lockPiece)
`endif
   );

   function automatic int ref_period(input int lv, input bit sd);
      int p;
      p = BASE_PERIOD - lv * STEP;
      if (p < 0) p = 0;
      if (p < MIN_PERIOD) p = MIN_PERIOD;
      if (sd) begin
         p = p >> SOFT_SHIFT;
         if (p < 1) p = 1;
      end
      return p;
   endfunction

   task automatic check_eq(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_md  = 1'b0;
      m_lc  = 0;
      m_lp  = 1'b0;
   endtask

   // One clock: advance the model with the inputs the DUT sampled, then compare.
   task automatic step();
      int p;
      @(posedge clk);
      p = ref_period(int'(level), softDrop);
`ifdef GRAVITY_LOCK_EN
      if (!grounded || rstTimer) begin
         m_lc = 0; m_lp = 1'b0;
      end else if (pause) begin
         m_lp = 1'b0;
      end else if (m_lc >= LOCK_PERIOD - 1) begin
         m_lc = 0; m_lp = 1'b1;
      end else begin
         m_lc++; m_lp = 1'b0;
      end
`endif
      if (rstTimer) begin
         m_cnt = 0; m_md = 1'b0;
      end else if (pause) begin
         m_md = 1'b0;
      end else if (m_cnt >= p - 1) begin
         m_cnt = 0; m_md = 1'b1;
      end else begin
         m_cnt++; m_md = 1'b0;
      end
      #1;
      check_eq("timeVal", int'(timeVal), m_cnt);
      check_eq("moveDown", int'(moveDown), (m_md && !m_lp) ? 1 : 0);
`ifdef GRAVITY_LOCK_EN
      check_eq("lockPiece", int'(lockPiece), int'(m_lp));
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (m_cnt != target && n < 400) begin
         step();
         n++;
      end
      if (m_cnt != target) check_eq("run_to_timeout", m_cnt, target);
   endtask

   task automatic restart();
      rstTimer = 1'b1;
      step();
      rstTimer = 1'b0;
   endtask

   task automatic gap_to_pulse(input string tag, input int exp);
      int gap;
      gap = -1;
      for (int i = 1; i <= 200 && gap < 0; i++) begin
         step();
         if (moveDown) gap = i;
      end
      check_eq(tag, gap, exp);
   endtask

   initial begin
      int first_pulse;
      int lock_at;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_timeVal", int'(timeVal), 0);
      check_eq("reset_moveDown", int'(moveDown), 0);
      rst = 1'b1;
      model_reset();

      // Test 1: level 0, first pulse 100 cycles after release, then every 100
      first_pulse = -1;
      for (int i = 1; i <= 250; i++) begin
         step();
         if (moveDown && first_pulse < 0) first_pulse = i;
      end
      check_eq("first_pulse_cycle", first_pulse, 100);

      // Test 2: level-derived periods and mid-count shrink
      level = 4'd3;
      restart();
      gap_to_pulse("level3_period", 70);
      gap_to_pulse("level3_period_again", 70);
      level = 4'd15;
      gap_to_pulse("level15_first", 20);
      gap_to_pulse("level15_period", 20);
      level = 4'd0;
      restart();
      run_to(50);
      level = 4'd9;
      step();
      check_eq("shrink_pulse", int'(moveDown), 1);
      check_eq("shrink_count", int'(timeVal), 0);
      gap_to_pulse("level9_period", 20);

      // Test 3: soft drop
      level = 4'd0;
      softDrop = 1'b1;
      restart();
      gap_to_pulse("soft_l0_period", 25);
      gap_to_pulse("soft_l0_again", 25);
      level = 4'd15;
      gap_to_pulse("soft_l15_first", 5);
      gap_to_pulse("soft_l15_period", 5);
      softDrop = 1'b0;
      level = 4'd0;
      restart();
      gap_to_pulse("soft_release_period", 100);

      // Test 4: restart, restart on terminal, asynchronous reset
      run_to(60);
      restart();
      check_eq("restart_count", int'(timeVal), 0);
      gap_to_pulse("restart_gap", 100);
      run_to(99);
      rstTimer = 1'b1;
      step();
      rstTimer = 1'b0;
      check_eq("restart_on_terminal_pulse", int'(moveDown), 0);
      check_eq("restart_on_terminal_count", int'(timeVal), 0);
      run_to(30);
      #3;
      rst = 1'b0;
      #1;
      check_eq("async_reset_timeVal", int'(timeVal), 0);
      check_eq("async_reset_moveDown", int'(moveDown), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      gap_to_pulse("post_async_reset_gap", 100);

      // Test 5: pause
      run_to(40);
      pause = 1'b1;
      run(30);
      check_eq("pause_frozen", int'(timeVal), 40);
      pause = 1'b0;
      gap_to_pulse("pause_late_pulse", 60);
      run_to(25);
      pause = 1'b1;
      run(3);
      restart();
      check_eq("restart_in_pause", int'(timeVal), 0);
      run(5);
      pause = 1'b0;

`ifdef GRAVITY_LOCK_EN
      // Test 6: lock delay
      level = 4'd0;
      restart();
      grounded = 1'b1;
      lock_at = -1;
      for (int i = 1; i <= 60 && lock_at < 0; i++) begin
         step();
         if (lockPiece) lock_at = i;
      end
      check_eq("lock_first_pulse", lock_at, 50);
      run(49);
      grounded = 1'b0;
      step();
      check_eq("lock_drop_at_49", int'(lockPiece), 0);
      level = 4'd5;
      grounded = 1'b1;
      restart();
      run(50);
      check_eq("lock_coincide_lock", int'(lockPiece), 1);
      check_eq("lock_coincide_move", int'(moveDown), 0);
      grounded = 1'b0;
      step();
`else
      lock_at = 0;
`endif

      // Randomized phase
      level = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(49) == 0) level = LEVEL_W'($urandom_range(15));
         if ($urandom_range(59) == 0) softDrop = ~softDrop;
         if ($urandom_range(39) == 0) pause = ~pause;
         rstTimer = ($urandom_range(79) == 0);
`ifdef GRAVITY_LOCK_EN
         if ($urandom_range(69) == 0) grounded = ~grounded;
`endif
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
